vector_mem_sequencer: RTL and testbench

Sequences the single-word data-memory port for decoded memory instructions of the 4-lane SIMD datapath. Sits between the instruction decoder and the data memory/lane register files. For lane-serial ops (vector=0) it steps an element counter over all lanes, one word per lane. For broadcast ops (vector=1) it performs one access. While an op is in flight it stalls fetch.

---
 rtl/vector_mem_sequencer_if.sv | 49 ++++
 rtl/vector_mem_sequencer.sv | 137 +++++++++++++
 tb/tb_vector_mem_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_mem_sequencer_if.sv
// Decoder-side and data-memory-side signals of the vector memory sequencer.
// The master drives decoded ops and memory responses; the slave is the sequencer.
interface vector_mem_sequencer_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int IDX_W = $clog2(LANES);

  logic                    issue;
  logic                    mem_load_enable;
  logic                    mem_write_enable;
  logic                    vector;
  logic [1:0]              addr_mode;
  logic [ADDR_W-1:0]       imm_addr;
  logic [ADDR_W-1:0]       reg_addr_value;
  logic [3:0]              reg_write_address;
  logic [LANES*DATA_W-1:0] store_data;
  logic                    mem_ready;
  logic [DATA_W-1:0]       mem_rdata;

  logic                    stall;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [LANES-1:0]        lane_we;
  logic [DATA_W-1:0]       lane_wdata;
  logic [3:0]              lane_waddr;
  logic [IDX_W-1:0]        lane_index;
  logic                    done;
  logic                    err;

  modport master (
    output issue, mem_load_enable, mem_write_enable, vector, addr_mode,
           imm_addr, reg_addr_value, reg_write_address, store_data,
           mem_ready, mem_rdata,
    input  stall, mem_addr, mem_re, mem_we, mem_wdata, lane_we, lane_wdata,
           lane_waddr, lane_index, done, err
  );

  modport slave (
    input  issue, mem_load_enable, mem_write_enable, vector, addr_mode,
           imm_addr, reg_addr_value, reg_write_address, store_data,
           mem_ready, mem_rdata,
    output stall, mem_addr, mem_re, mem_we, mem_wdata, lane_we, lane_wdata,
           lane_waddr, lane_index, done, err
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Sequences the single-word data-memory port for decoded SIMD memory ops:
// lane-serial ops step over every lane, broadcast ops do one access.
module vector_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  vector_mem_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, SEQ, BCAST, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        counter_q, counter_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic                    load_q, load_d;
  logic [3:0]              waddr_q, waddr_d;
  logic [LANES*DATA_W-1:0] store_q, store_d;
  logic                    err_q, err_d;

  logic                    op_one;
  logic                    accept;
  logic                    reject;
  logic [ADDR_W-1:0]       issue_base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      base_q    <= '0;
      load_q    <= 1'b0;
      waddr_q   <= '0;
      store_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      base_q    <= base_d;
      load_q    <= load_d;
      waddr_q   <= waddr_d;
      store_q   <= store_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    op_one = bus.mem_load_enable ^ bus.mem_write_enable;
    accept = bus.issue && op_one && (bus.addr_mode != 2'b00);
    reject = bus.issue && ((bus.mem_load_enable && bus.mem_write_enable) ||
                           (op_one && (bus.addr_mode == 2'b00)));
    case (bus.addr_mode)
      2'b01:   issue_base = bus.imm_addr;
      2'b10:   issue_base = bus.reg_addr_value;
      2'b11:   issue_base = bus.reg_addr_value + bus.imm_addr;
      default: issue_base = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    base_d    = base_q;
    load_d    = load_q;
    waddr_d   = waddr_q;
    store_d   = store_q;
    err_d     = 1'b0;

    bus.mem_addr   = '0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = '0;
    bus.lane_we    = '0;
    bus.done       = 1'b0;
    bus.stall      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d    = issue_base;
          load_d    = bus.mem_load_enable;
          waddr_d   = bus.reg_write_address;
          store_d   = bus.store_data;
          counter_d = '0;
          state_d   = bus.vector ? BCAST : SEQ;
          bus.stall = 1'b1;
        end else if (reject) begin
          err_d = 1'b1;
        end
      end

      SEQ: begin
        bus.stall     = 1'b1;
        bus.mem_addr  = base_q + ADDR_W'(counter_q);
        bus.mem_re    = load_q;
        bus.mem_we    = !load_q;
        bus.mem_wdata = store_q[int'(counter_q)*DATA_W +: DATA_W];
        // Counter and lane_we only move on a completed access; everything else holds.
        if (bus.mem_ready) begin
          if (load_q) bus.lane_we = LANES'(1) << counter_q;
          if (counter_q == IDX_W'(LANES-1)) begin
            counter_d = '0;
            state_d   = DONE;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end

      BCAST: begin
        bus.stall     = 1'b1;
        bus.mem_addr  = base_q;
        bus.mem_re    = load_q;
        bus.mem_we    = !load_q;
        bus.mem_wdata = store_q[DATA_W-1:0];
        if (bus.mem_ready) begin
          if (load_q) bus.lane_we = '1;
          state_d = DONE;
        end
      end

      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.lane_wdata = bus.mem_rdata;
  assign bus.lane_waddr = waddr_q;
  assign bus.lane_index = counter_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed self-checking bench for vector_mem_sequencer (LANES=4, 32-bit).
module tb_vector_mem_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vector_mem_sequencer_if #(.LANES(4), .ADDR_W(32), .DATA_W(32)) bus ();

  vector_mem_sequencer #(.LANES(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {stall, mem_re, mem_we, done, err, lane_we[3:0]}
  function automatic logic [8:0] flags();
    return {bus.stall, bus.mem_re, bus.mem_we, bus.done, bus.err, bus.lane_we};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue             = 1'b0;
    bus.mem_load_enable   = 1'b0;
    bus.mem_write_enable  = 1'b0;
    bus.vector            = 1'b0;
    bus.addr_mode         = 2'b00;
    bus.imm_addr          = '0;
    bus.reg_addr_value    = '0;
    bus.reg_write_address = '0;
    bus.store_data        = '0;
    bus.mem_ready         = 1'b1;
    bus.mem_rdata         = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (flags() !== 9'h000) begin errors++; $display("FAIL reset_flags got %h exp %h", flags(), 9'h000); end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.lane_waddr !== 4'h0 || bus.lane_index !== 2'd0) begin
      errors++; $display("FAIL reset_regs got addr=%h waddr=%h idx=%0d exp 0", bus.mem_addr, bus.lane_waddr, bus.lane_index);
    end
    reset = 1'b0;
    tick();
  endtask

  // Lane-serial load at a direct immediate address, memory always ready.
  task automatic run_serial_load(input logic [31:0] base, input logic [3:0] wa, input string name);
    logic [31:0] a;
    clear_inputs();
    bus.issue = 1'b1; bus.mem_load_enable = 1'b1; bus.vector = 1'b0;
    bus.addr_mode = 2'b01; bus.imm_addr = base; bus.reg_write_address = wa;
    #1;
    checks++;
    if (flags() !== 9'b1_0000_0000) begin errors++; $display("FAIL %s_issue flags got %h exp %h", name, flags(), 9'b1_0000_0000); end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.issue = 1'b0;
      a = base + 32'(i);
      bus.mem_rdata = 32'hA0 + a;
      #1;
      checks++;
      if (flags() !== {5'b1_1000, 4'(1 << i)}) begin errors++; $display("FAIL %s_lane%0d flags got %h exp %h", name, i, flags(), {5'b1_1000, 4'(1 << i)}); end
      checks++;
      if (bus.mem_addr !== a || bus.lane_index !== 2'(i)) begin errors++; $display("FAIL %s_lane%0d addr got %h/%0d exp %h/%0d", name, i, bus.mem_addr, bus.lane_index, a, i); end
      checks++;
      if (bus.lane_wdata !== 32'hA0 + a || bus.lane_waddr !== wa) begin errors++; $display("FAIL %s_lane%0d wdata got %h/%h exp %h/%h", name, i, bus.lane_wdata, bus.lane_waddr, 32'hA0 + a, wa); end
    end
    tick();
    bus.mem_rdata = '0;
    #1;
    checks++;
    if (flags() !== 9'b0_0010_0000) begin errors++; $display("FAIL %s_done flags got %h exp %h", name, flags(), 9'b0_0010_0000); end
    tick();
    checks++;
    if (flags() !== 9'h000) begin errors++; $display("FAIL %s_after flags got %h exp %h", name, flags(), 9'h000); end
  endtask

  task automatic test_serial_load();
    run_serial_load(32'h10, 4'h5, "sload");
  endtask

  task automatic test_wrap();
    run_serial_load(32'hFFFF_FFFE, 4'h9, "wrap");
  endtask

  task automatic test_bcast_load();
    clear_inputs();
    bus.issue = 1'b1; bus.mem_load_enable = 1'b1; bus.vector = 1'b1;
    bus.addr_mode = 2'b11; bus.reg_addr_value = 32'h100; bus.imm_addr = 32'h4;
    bus.reg_write_address = 4'h7;
    #1;
    checks++;
    if (flags() !== 9'b1_0000_0000) begin errors++; $display("FAIL bload_issue flags got %h exp %h", flags(), 9'b1_0000_0000); end
    tick();
    bus.issue = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (flags() !== 9'b1_1000_1111) begin errors++; $display("FAIL bload_access flags got %h exp %h", flags(), 9'b1_1000_1111); end
    checks++;
    if (bus.mem_addr !== 32'h104 || bus.lane_wdata !== 32'hDEAD_BEEF || bus.lane_waddr !== 4'h7) begin
      errors++; $display("FAIL bload_data got %h/%h/%h exp 104/deadbeef/7", bus.mem_addr, bus.lane_wdata, bus.lane_waddr);
    end
    tick();
    checks++;
    if (flags() !== 9'b0_0010_0000) begin errors++; $display("FAIL bload_done flags got %h exp %h", flags(), 9'b0_0010_0000); end
    tick();
  endtask

  task automatic test_bcast_store_stall();
    clear_inputs();
    bus.issue = 1'b1; bus.mem_write_enable = 1'b1; bus.vector = 1'b1;
    bus.addr_mode = 2'b10; bus.reg_addr_value = 32'h300;
    bus.store_data = {32'h44, 32'h33, 32'h22, 32'h55};
    tick();
    bus.issue = 1'b0; bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (flags() !== 9'b1_0100_0000 || bus.mem_wdata !== 32'h55 || bus.mem_addr !== 32'h300) begin
      errors++; $display("FAIL bstore_wait got %h/%h/%h exp %h/55/300", flags(), bus.mem_wdata, bus.mem_addr, 9'b1_0100_0000);
    end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (flags() !== 9'b1_0100_0000 || bus.mem_wdata !== 32'h55) begin
      errors++; $display("FAIL bstore_go got %h/%h exp %h/55", flags(), bus.mem_wdata, 9'b1_0100_0000);
    end
    tick();
    checks++;
    if (flags() !== 9'b0_0010_0000) begin errors++; $display("FAIL bstore_done flags got %h exp %h", flags(), 9'b0_0010_0000); end
    tick();
  endtask

  task automatic test_store_backpressure();
    int lane_seq [5] = '{0, 1, 1, 2, 3};
    logic rdy_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    clear_inputs();
    bus.issue = 1'b1; bus.mem_write_enable = 1'b1; bus.vector = 1'b0;
    bus.addr_mode = 2'b10; bus.reg_addr_value = 32'h200;
    bus.store_data = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.issue = 1'b0;
      bus.mem_ready = rdy_seq[c];
      #1;
      checks++;
      if (flags() !== 9'b1_0100_0000) begin errors++; $display("FAIL sstore_c%0d flags got %h exp %h", c + 1, flags(), 9'b1_0100_0000); end
      checks++;
      if (bus.mem_wdata !== 32'(lane_seq[c] + 1) || bus.mem_addr !== 32'h200 + 32'(lane_seq[c])) begin
        errors++; $display("FAIL sstore_c%0d data got %h@%h exp %h@%h", c + 1, bus.mem_wdata, bus.mem_addr, lane_seq[c] + 1, 32'h200 + 32'(lane_seq[c]));
      end
    end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (flags() !== 9'b0_0010_0000) begin errors++; $display("FAIL sstore_done flags got %h exp %h", flags(), 9'b0_0010_0000); end
    tick();
  endtask

  task automatic test_errors();
    logic [1:0] mode [3] = '{2'b01, 2'b00, 2'b01};
    logic       ld   [3] = '{1'b1, 1'b1, 1'b0};
    logic       st   [3] = '{1'b1, 1'b0, 1'b0};
    logic       xerr [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      bus.issue = 1'b1; bus.addr_mode = mode[k];
      bus.mem_load_enable = ld[k]; bus.mem_write_enable = st[k];
      #1;
      checks++;
      if (flags() !== 9'h000) begin errors++; $display("FAIL err%0d_issue flags got %h exp %h", k, flags(), 9'h000); end
      tick();
      bus.issue = 1'b0;
      #1;
      checks++;
      if (flags() !== {4'b0000, xerr[k], 4'b0000}) begin errors++; $display("FAIL err%0d_pulse flags got %h exp %h", k, flags(), {4'b0000, xerr[k], 4'b0000}); end
      tick();
      checks++;
      if (flags() !== 9'h000) begin errors++; $display("FAIL err%0d_after flags got %h exp %h", k, flags(), 9'h000); end
    end
  endtask

  // Issue held high: ignored while busy, re-evaluated the cycle after DONE.
  task automatic test_back_to_back();
    logic [8:0] exp [5] = '{9'b1_0000_0000, 9'b1_1000_1111, 9'b0_0010_0000, 9'b1_0000_0000, 9'b1_1000_1111};
    clear_inputs();
    bus.issue = 1'b1; bus.mem_load_enable = 1'b1; bus.vector = 1'b1;
    bus.addr_mode = 2'b01; bus.imm_addr = 32'h80;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      checks++;
      if (flags() !== exp[c]) begin errors++; $display("FAIL b2b_c%0d flags got %h exp %h", c, flags(), exp[c]); end
    end
    bus.issue = 1'b0;
    tick();
    checks++;
    if (flags() !== 9'b0_0010_0000) begin errors++; $display("FAIL b2b_done flags got %h exp %h", flags(), 9'b0_0010_0000); end
    tick();
  endtask

  task automatic test_reset_mid_seq();
    clear_inputs();
    bus.issue = 1'b1; bus.mem_load_enable = 1'b1; bus.vector = 1'b0;
    bus.addr_mode = 2'b01; bus.imm_addr = 32'h20; bus.reg_write_address = 4'hC;
    tick();
    bus.issue = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (bus.lane_index !== 2'd2 || bus.mem_addr !== 32'h22) begin errors++; $display("FAIL rmid_pre got %0d@%h exp 2@22", bus.lane_index, bus.mem_addr); end
    reset = 1'b1;
    #1;
    checks++;
    if (flags() !== 9'h000 || bus.mem_addr !== 32'h0 || bus.lane_index !== 2'd0 || bus.lane_waddr !== 4'h0) begin
      errors++; $display("FAIL rmid_async got %h/%h/%0d/%h exp 0", flags(), bus.mem_addr, bus.lane_index, bus.lane_waddr);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (flags() !== 9'h000) begin errors++; $display("FAIL rmid_nodone%0d flags got %h exp %h", c, flags(), 9'h000); end
    end
    run_serial_load(32'h40, 4'h3, "rmid_next");
  endtask

  initial begin
    test_reset();
    test_serial_load();
    test_bcast_load();
    test_store_backpressure();
    test_bcast_store_stall();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_reset_mid_seq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
